// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Collects registered add/sub result words {result[7:0], carry/borrow} into a
//   show-ahead FIFO. Buffered words go to the consumer over a valid/ready
//   handshake. Running statistics are kept on every accepted word.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid, in_data     incoming result word, bits [8:1] = result, bit [0] = flag
//   out_valid, out_ready  head handshake; pop = out_valid & out_ready
//   out_data              FIFO head, same packing as in_data (0 while empty)
//   level, full           occupancy 0..DEPTH and level == DEPTH
//   clear_stats           synchronous clear of acc_sum, flag_cnt, overflow
//   acc_sum               wrap-around sum of accepted results
//   flag_cnt              saturating count of accepted words with flag set
//   overflow              sticky: a word was dropped on a full FIFO
module alu_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SUM_W = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [8:0]                   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8:0]                   out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  input  logic                         clear_stats,
  output logic [SUM_W-1:0]             acc_sum,
  output logic [7:0]                   flag_cnt,
  output logic                         overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] PtrOne   = 1;
  localparam logic [LvlW-1:0] LvlOne   = 1;
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(DEPTH);
  localparam logic [7:0]      FlagMax  = 8'hFF;

  logic [8:0]       r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]  r_level, w_level_d;
  logic [SUM_W-1:0] r_acc_sum, w_acc_sum_d;
  logic [7:0]       r_flag_cnt, w_flag_cnt_d;
  logic             r_overflow, w_overflow_d;

  logic w_empty, w_full, w_pop, w_push, w_drop;

  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LvlFull);
  assign w_pop   = ~w_empty & out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  // Storage needs no reset: reading is qualified by level.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LvlOne;
      2'b01:   w_level_d = r_level - LvlOne;
      default: w_level_d = r_level;
    endcase
  end

  // clear_stats wins over any update in the same cycle, including a drop.
  always_comb begin
    w_acc_sum_d  = r_acc_sum;
    w_flag_cnt_d = r_flag_cnt;
    w_overflow_d = r_overflow;
    if (clear_stats) begin
      w_acc_sum_d  = '0;
      w_flag_cnt_d = '0;
      w_overflow_d = 1'b0;
    end else begin
      if (w_push) begin
        w_acc_sum_d = r_acc_sum + SUM_W'(in_data[8:1]);
        if (in_data[0] && (r_flag_cnt != FlagMax)) begin
          w_flag_cnt_d = r_flag_cnt + 8'd1;
        end
      end
      if (w_drop) begin
        w_overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_acc_sum  <= '0;
      r_flag_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      r_level    <= w_level_d;
      r_acc_sum  <= w_acc_sum_d;
      r_flag_cnt <= w_flag_cnt_d;
      r_overflow <= w_overflow_d;
    end
  end

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? 9'h000 : r_mem[r_rd_ptr];
  assign level     = r_level;
  assign full      = w_full;
  assign acc_sum   = r_acc_sum;
  assign flag_cnt  = r_flag_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  localparam int DEPTH = 4;
  localparam int SUM_W = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_data;
  logic [2:0]  level;
  logic        full;
  logic        clear_stats = 1'b0;
  logic [15:0] acc_sum;
  logic [7:0]  flag_cnt;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queue plus integer statistics.
  logic [8:0] m_q[$];
  int         m_sum;
  int         m_fcnt;
  bit         m_ovf;

  alu_result_collector #(.DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .full       (full),
    .clear_stats(clear_stats),
    .acc_sum    (acc_sum),
    .flag_cnt   (flag_cnt),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sum  = 0;
    m_fcnt = 0;
    m_ovf  = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(m_q[0]));
    chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
    chk({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, ".sum"}, 32'(acc_sum), 32'(m_sum));
    chk({tag, ".fcnt"}, 32'(flag_cnt), 32'(m_fcnt));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Apply inputs (at negedge), clock once, update model, check 1 time unit after the edge.
  task automatic step(input string tag, input bit v, input logic [8:0] d, input bit r,
                      input bit c);
    bit pop, push;
    in_valid = v; in_data = d; out_ready = r; clear_stats = c;
    @(posedge clock);
    pop  = (m_q.size() != 0) && r;
    push = v && ((m_q.size() < DEPTH) || pop);
    if (c) begin
      m_sum = 0; m_fcnt = 0; m_ovf = 0;
    end else begin
      if (push) begin
        m_sum = (m_sum + int'(d[8:1])) % 65536;
        if (d[0] && m_fcnt < 255) m_fcnt++;
      end
      if (v && !push) m_ovf = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    #1;
    check_model(tag);
    @(negedge clock);
    in_valid = 0; out_ready = 0; clear_stats = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0;
    #1;
    model_reset();
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.data", 32'(out_data), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.stats", {acc_sum, flag_cnt, 7'b0, overflow}, 0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset mid-stream
    step("mid.p0", 1, 9'h013, 0, 0);
    step("mid.p1", 1, 9'h122, 0, 0);
    step("mid.p2", 1, 9'h031, 0, 0);
    do_reset();
    // No bypass: in_valid on an empty FIFO does not raise out_valid combinationally
    in_valid = 1; in_data = 9'h0A5; #1;
    chk("nobypass", 32'(out_valid), 0);
    step("mid.push", 1, 9'h0A5, 0, 0);
    chk("mid.a5", 32'(out_data), 32'h0A5);

    // Ordering and latency
    do_reset();
    step("ord.p0", 1, 9'h024, 0, 0);
    chk("ord.first_valid", 32'(out_valid), 1);
    step("ord.p1", 1, 9'h1FF, 0, 0);
    step("ord.p2", 1, 9'h001, 0, 0);
    chk("ord.h0", 32'(out_data), 32'h024);
    step("ord.d0", 0, 9'h0, 1, 0);
    chk("ord.h1", 32'(out_data), 32'h1FF);
    step("ord.d1", 0, 9'h0, 1, 0);
    chk("ord.h2", 32'(out_data), 32'h001);
    step("ord.d2", 0, 9'h0, 1, 0);
    chk("ord.sum", 32'(acc_sum), 32'h0111);
    chk("ord.fcnt", 32'(flag_cnt), 2);

    // Full and drop
    do_reset();
    for (int i = 0; i < 5; i++) step("full.push", 1, 9'($urandom), 0, 0);
    chk("full.full", 32'(full), 1);
    chk("full.ovf", 32'(overflow), 1);
    step("full.clr", 0, 9'h0, 0, 1);
    chk("full.ovf_clr", 32'(overflow), 0);
    chk("full.level", 32'(level), 4);

    // Full with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 6; i++) step("fpp", 1, 9'($urandom), 1, 0);
    chk("fpp.level", 32'(level), 4);
    chk("fpp.ovf", 32'(overflow), 0);

    // Sum wrap and flag saturation
    do_reset();
    for (int i = 0; i < 300; i++) step("sat", 1, 9'h1FF, 1, 0);
    chk("sat.sum", 32'(acc_sum), 32'h2AD4);
    chk("sat.fcnt", 32'(flag_cnt), 255);

    // clear_stats coincident with a push
    do_reset();
    step("clr.pre", 1, 9'h1FF, 1, 0);
    step("clr.drain", 0, 9'h0, 1, 0);
    step("clr.push", 1, 9'h081, 0, 1);
    chk("clr.stats", {acc_sum, flag_cnt, 7'b0, overflow}, 0);
    chk("clr.data", 32'(out_data), 32'h081);
    step("clr.pop", 0, 9'h0, 1, 0);

    // Randomized traffic, including drops, clears and stalls
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rnd", bit'($urandom_range(0, 3) != 0), 9'($urandom),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
